// File: rtl/threshold_compress.sv
// Purpose: thresholds signed preactivations into trits and packs N_TRITS of them base-3 into one output word.
// Latency: data_o/compreg_full_o valid right after the edge capturing the last trit of a group; ready_o strobes one cycle.
// Backpressure: none; enable_i may be asserted every cycle or with arbitrary gaps.
module threshold_compress #(
    parameter int OUTPUT_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [31:0]             data_i,
    input  logic [31:0]             thresholds_i,
    input  logic                    enable_i,
    output logic [OUTPUT_WIDTH-1:0] data_o,
    output logic                    ready_o,
    output logic                    compreg_full_o
);

    localparam int COMPREG_WIDTH = OUTPUT_WIDTH * 5 / 4;
    localparam int N_TRITS       = COMPREG_WIDTH / 2;
    localparam int CNT_W         = $clog2(N_TRITS + 1);

    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_NEG  = 2'b11;
    localparam logic [1:0] TRIT_ZERO = 2'b00;

    logic signed [31:0] data_s;
    logic signed [31:0] thr_hi;
    logic signed [31:0] thr_lo;
    logic [1:0]         trit_code;

    logic [COMPREG_WIDTH-1:0] compreg_d, compreg_q;
    logic [CNT_W-1:0]         cnt_d, cnt_q;
    logic [OUTPUT_WIDTH-1:0]  data_d, data_q;
    logic                     ready_d, ready_q;
    logic                     full_d, full_q;

    assign data_s = data_i;
    assign thr_hi = {{16{thresholds_i[31]}}, thresholds_i[31:16]};
    assign thr_lo = {{16{thresholds_i[15]}}, thresholds_i[15:0]};

    // +1 is tested first so an inverted threshold pair still resolves deterministically
    always_comb begin
        trit_code = TRIT_ZERO;
        if (data_s > thr_hi) begin
            trit_code = TRIT_POS;
        end else if (data_s < thr_lo) begin
            trit_code = TRIT_NEG;
        end
    end

    // Horner evaluation from the most significant slot; slot 0 is the least significant digit
    function automatic logic [OUTPUT_WIDTH-1:0] pack(input logic [COMPREG_WIDTH-1:0] c);
        logic [OUTPUT_WIDTH-1:0] acc;
        acc = '0;
        for (int k = N_TRITS - 1; k >= 0; k--) begin
            acc = acc * OUTPUT_WIDTH'(3);
            case (c[2*k +: 2])
                TRIT_POS: acc = acc + OUTPUT_WIDTH'(2);
                TRIT_NEG: acc = acc;
                default:  acc = acc + OUTPUT_WIDTH'(1);
            endcase
        end
        return acc;
    endfunction

    always_comb begin
        compreg_d = compreg_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        full_d    = full_q;
        if (enable_i) begin
            if (cnt_q == CNT_W'(N_TRITS)) begin
                compreg_d      = '0;
                compreg_d[1:0] = trit_code;
                cnt_d          = CNT_W'(1);
                full_d         = 1'b0;
            end else begin
                for (int k = 0; k < N_TRITS; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        compreg_d[2*k +: 2] = trit_code;
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N_TRITS - 1)) begin
                    full_d  = 1'b1;
                    ready_d = 1'b1;
                    data_d  = pack(compreg_d);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            compreg_q <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            compreg_q <= compreg_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            full_q    <= full_d;
        end
    end

    assign data_o         = data_q;
    assign ready_o        = ready_q;
    assign compreg_full_o = full_q;

endmodule

// File: tb/tb_threshold_compress.sv
// Directed bench for threshold_compress: hand-computed packed words, strobe timing and reset behaviour.
module tb_threshold_compress;

    localparam logic [31:0] THR_STD = 32'h0064_FF9C;  // hi=100, lo=-100
    localparam logic [31:0] THR_BND = 32'h7FFF_8000;  // hi=32767, lo=-32768
    localparam logic [31:0] THR_INV = 32'hFFFB_0005;  // hi=-5, lo=5
    localparam logic [31:0] P200 = 32'd200;
    localparam logic [31:0] M200 = 32'hFFFF_FF38;

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] data_i;
    logic [31:0] thresholds_i;
    logic        enable_i;
    logic [7:0]  data_o;
    logic        ready_o;
    logic        compreg_full_o;

    int n_chk;
    int n_pass;

    threshold_compress #(.OUTPUT_WIDTH(8)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .data_i         (data_i),
        .thresholds_i   (thresholds_i),
        .enable_i       (enable_i),
        .data_o         (data_o),
        .ready_o        (ready_o),
        .compreg_full_o (compreg_full_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Presents one enabled sample, consumes one edge, returns 1 ns after it with enable low.
    task automatic push(input logic [31:0] d, input logic [31:0] thr);
        enable_i     = 1'b1;
        data_i       = d;
        thresholds_i = thr;
        @(posedge clk_i);
        #1;
        enable_i = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic group_same(input logic [31:0] d, input logic [31:0] thr);
        for (int i = 0; i < 5; i++) push(d, thr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk        = 0;
        n_pass       = 0;
        rst_ni       = 1'b0;
        enable_i     = 1'b0;
        data_i       = '0;
        thresholds_i = '0;
        #1;
        chk("rst_data", {24'd0, data_o}, 32'd0);
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        chk("rst_full", {31'd0, compreg_full_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle();

        // All +1
        for (int i = 0; i < 4; i++) push(P200, THR_STD);
        chk("p200_full_early", {31'd0, compreg_full_o}, 32'd0);
        chk("p200_ready_early", {31'd0, ready_o}, 32'd0);
        push(P200, THR_STD);
        chk("p200_full", {31'd0, compreg_full_o}, 32'd1);
        chk("p200_data", {24'd0, data_o}, 32'hF2);
        chk("p200_ready", {31'd0, ready_o}, 32'd1);
        idle();
        chk("p200_ready_drop", {31'd0, ready_o}, 32'd0);
        chk("p200_full_hold", {31'd0, compreg_full_o}, 32'd1);
        chk("p200_data_hold", {24'd0, data_o}, 32'hF2);

        // All -1, then all 0
        push(M200, THR_STD);
        chk("newgrp_full_drop", {31'd0, compreg_full_o}, 32'd0);
        chk("newgrp_data_hold", {24'd0, data_o}, 32'hF2);
        for (int i = 0; i < 4; i++) push(M200, THR_STD);
        chk("m200_data", {24'd0, data_o}, 32'h00);
        chk("m200_ready", {31'd0, ready_o}, 32'd1);
        group_same(32'd0, THR_STD);
        chk("zero_data", {24'd0, data_o}, 32'h79);
        chk("zero_full", {31'd0, compreg_full_o}, 32'd1);

        // Slot order and threshold equality: digits 2,0,1,1,0
        push(P200, THR_STD);
        push(M200, THR_STD);
        push(32'd0, THR_STD);
        push(32'd100, THR_STD);
        push(32'hFFFF_FF9B, THR_STD);  // -101
        chk("mixed_data", {24'd0, data_o}, 32'h26);

        // Digits 1,2,0,2,1 back-to-back
        push(32'd0, THR_STD);
        push(P200, THR_STD);
        push(M200, THR_STD);
        push(P200, THR_STD);
        push(32'd0, THR_STD);
        chk("b2b_data", {24'd0, data_o}, 32'h8E);
        group_same(M200, THR_STD);
        chk("b2b_clear", {24'd0, data_o}, 32'h00);

        // Same digits with a gap after every sample
        push(32'd0, THR_STD);   idle();
        push(P200, THR_STD);    idle();
        push(M200, THR_STD);    idle();
        chk("gap_full_mid", {31'd0, compreg_full_o}, 32'd0);
        push(P200, THR_STD);    idle();
        push(32'd0, THR_STD);
        chk("gap_data", {24'd0, data_o}, 32'h8E);
        chk("gap_ready", {31'd0, ready_o}, 32'd1);
        idle();
        idle();
        chk("gap_data_stable", {24'd0, data_o}, 32'h8E);
        chk("gap_full_stable", {31'd0, compreg_full_o}, 32'd1);
        chk("gap_ready_low", {31'd0, ready_o}, 32'd0);

        // Reset mid-group discards partial trits
        push(P200, THR_STD);
        push(P200, THR_STD);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("midrst_data", {24'd0, data_o}, 32'd0);
        chk("midrst_full", {31'd0, compreg_full_o}, 32'd0);
        chk("midrst_ready", {31'd0, ready_o}, 32'd0);
        #2;
        rst_ni = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) push(M200, THR_STD);
        chk("postrst_full_3", {31'd0, compreg_full_o}, 32'd0);
        push(M200, THR_STD);
        chk("postrst_full_4", {31'd0, compreg_full_o}, 32'd0);
        push(M200, THR_STD);
        chk("postrst_full_5", {31'd0, compreg_full_o}, 32'd1);
        chk("postrst_data", {24'd0, data_o}, 32'h00);

        // Extreme data values against extreme thresholds: digits 2,0,2,0,2
        push(32'h7FFF_FFFF, THR_BND);
        push(32'h8000_0000, THR_BND);
        push(32'h7FFF_FFFF, THR_BND);
        push(32'h8000_0000, THR_BND);
        push(32'h7FFF_FFFF, THR_BND);
        chk("bound_data", {24'd0, data_o}, 32'hB6);

        // Per-sample thresholds, inverted pair gives +1: digits 2,1,0,1,1
        push(32'd0, THR_INV);
        push(32'd50, THR_STD);
        push(32'h8000_0000, THR_BND);
        push(32'd100, THR_STD);
        push(32'hFFFF_FF9C, THR_STD);  // -100
        chk("perthr_data", {24'd0, data_o}, 32'h71);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
